// File: rtl/uart_xbee_rx_if.sv
// Sample-side bus of the XBee UART receiver: decoded ADC samples and error reporting.
interface uart_xbee_rx_if;
    logic        sample_valid;
    logic [2:0]  sample_ch;
    logic [11:0] sample_data;
    logic        frame_err;
    logic [7:0]  err_count;

    modport master (
        output sample_valid,
        output sample_ch,
        output sample_data,
        output frame_err,
        output err_count
    );

    modport slave (
        input sample_valid,
        input sample_ch,
        input sample_data,
        input frame_err,
        input err_count
    );
endinterface

// File: rtl/uart_xbee_rx.sv
// XBee UART receiver: 8-bit MSB-first bytes, assembled into two-byte frames carrying
// a 3-bit channel and a 12-bit ADC code.
//
// Byte receiver:
//   state   | meaning
//   R_IDLE  | waiting for a 1->0 edge on the synchronized line
//   R_START | timing to mid start bit, rejecting false starts
//   R_DATA  | sampling 8 data bits at mid-bit
//   R_STOP  | checking the stop bit
//   R_FLUSH | after a framing error, waiting for the line to return high
// Frame assembler:
//   state       | meaning
//   A_WAIT_HIGH | waiting for a byte with bit7=1 (channel + data[11:8])
//   A_WAIT_LOW  | waiting for data[7:0], guarded by the gap timer
module uart_xbee_rx #(
    parameter int CLKS_PER_BIT = 434,
    parameter int GAP_TIMEOUT  = 8680
) (
    input  logic           clk_50,
    input  logic           rst_n,
    input  logic           rx,
    uart_xbee_rx_if.master smp
);
    localparam int BT_W  = $clog2(CLKS_PER_BIT);
    localparam int GAP_W = $clog2(GAP_TIMEOUT);
    localparam logic [BT_W-1:0]  BIT_LAST  = BT_W'(CLKS_PER_BIT - 1);
    localparam logic [BT_W-1:0]  HALF_LAST = BT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [BT_W-1:0]  BT_ONE    = BT_W'(1);
    localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'(GAP_TIMEOUT - 1);
    localparam logic [GAP_W-1:0] GAP_ONE   = GAP_W'(1);

    typedef enum logic [2:0] {R_IDLE, R_START, R_DATA, R_STOP, R_FLUSH} rx_state_t;
    typedef enum logic {A_WAIT_HIGH, A_WAIT_LOW} asm_state_t;

    logic            rx_meta, rx_sync, rx_prev;
    logic [1:0]      settle;
    logic            fall;
    rx_state_t       rx_state;
    logic [BT_W-1:0] bit_tmr;
    logic [2:0]      bit_cnt;
    logic [7:0]      shreg;
    logic            byte_stb;
    logic            rx_ferr;

    asm_state_t       asm_state;
    logic [GAP_W-1:0] gap_tmr;
    logic [2:0]       hi_ch;
    logic [3:0]       hi_nib;
    logic             err_evt;
    logic             sample_valid_r;
    logic [2:0]       sample_ch_r;
    logic [11:0]      sample_data_r;
    logic             frame_err_r;
    logic [7:0]       err_count_r;

    // The synchronizer resets high, so the first two cycles after reset can show a
    // false 1->0 edge when the line is held low; edges are ignored until real data
    // has reached rx_prev.
    always_ff @(posedge clk_50 or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
            settle  <= 2'd0;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
            if (settle != 2'd3)
                settle <= settle + 2'd1;
        end
    end

    assign fall = (settle == 2'd3) && rx_prev && !rx_sync;

    always_ff @(posedge clk_50 or negedge rst_n) begin
        if (!rst_n) begin
            rx_state <= R_IDLE;
            bit_tmr  <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            byte_stb <= 1'b0;
            rx_ferr  <= 1'b0;
        end else begin
            byte_stb <= 1'b0;
            rx_ferr  <= 1'b0;
            case (rx_state)
                R_IDLE: begin
                    if (fall) begin
                        rx_state <= R_START;
                        bit_tmr  <= HALF_LAST;
                    end
                end
                R_START: begin
                    if (bit_tmr == '0) begin
                        if (!rx_sync) begin
                            rx_state <= R_DATA;
                            bit_tmr  <= BIT_LAST;
                            bit_cnt  <= '0;
                        end else begin
                            rx_state <= R_IDLE;
                        end
                    end else begin
                        bit_tmr <= bit_tmr - BT_ONE;
                    end
                end
                R_DATA: begin
                    if (bit_tmr == '0) begin
                        shreg   <= {shreg[6:0], rx_sync};
                        bit_tmr <= BIT_LAST;
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7)
                            rx_state <= R_STOP;
                    end else begin
                        bit_tmr <= bit_tmr - BT_ONE;
                    end
                end
                R_STOP: begin
                    if (bit_tmr == '0) begin
                        if (rx_sync) begin
                            byte_stb <= 1'b1;
                            rx_state <= R_IDLE;
                        end else begin
                            rx_ferr  <= 1'b1;
                            rx_state <= R_FLUSH;
                        end
                    end else begin
                        bit_tmr <= bit_tmr - BT_ONE;
                    end
                end
                R_FLUSH: begin
                    if (rx_sync)
                        rx_state <= R_IDLE;
                end
                default: rx_state <= R_IDLE;
            endcase
        end
    end

    // A byte arriving on the same cycle as the gap timeout takes precedence.
    always_comb begin
        err_evt = rx_ferr;
        if (asm_state == A_WAIT_HIGH && byte_stb && !shreg[7])
            err_evt = 1'b1;
        if (asm_state == A_WAIT_LOW && !byte_stb && gap_tmr == '0)
            err_evt = 1'b1;
    end

    always_ff @(posedge clk_50 or negedge rst_n) begin
        if (!rst_n) begin
            asm_state      <= A_WAIT_HIGH;
            gap_tmr        <= '0;
            hi_ch          <= '0;
            hi_nib         <= '0;
            sample_valid_r <= 1'b0;
            sample_ch_r    <= '0;
            sample_data_r  <= '0;
            frame_err_r    <= 1'b0;
            err_count_r    <= '0;
        end else begin
            sample_valid_r <= 1'b0;
            frame_err_r    <= err_evt;
            if (err_evt && err_count_r != 8'hFF)
                err_count_r <= err_count_r + 8'd1;
            case (asm_state)
                A_WAIT_HIGH: begin
                    if (byte_stb && shreg[7]) begin
                        hi_ch     <= shreg[6:4];
                        hi_nib    <= shreg[3:0];
                        gap_tmr   <= GAP_LAST;
                        asm_state <= A_WAIT_LOW;
                    end
                end
                A_WAIT_LOW: begin
                    if (byte_stb) begin
                        sample_valid_r <= 1'b1;
                        sample_ch_r    <= hi_ch;
                        sample_data_r  <= {hi_nib, shreg};
                        asm_state      <= A_WAIT_HIGH;
                    end else if (rx_ferr || gap_tmr == '0) begin
                        asm_state <= A_WAIT_HIGH;
                    end else begin
                        gap_tmr <= gap_tmr - GAP_ONE;
                    end
                end
                default: asm_state <= A_WAIT_HIGH;
            endcase
        end
    end

    assign smp.sample_valid = sample_valid_r;
    assign smp.sample_ch    = sample_ch_r;
    assign smp.sample_data  = sample_data_r;
    assign smp.frame_err    = frame_err_r;
    assign smp.err_count    = err_count_r;
endmodule

// File: tb/tb_uart_xbee_rx.sv
// Directed bench for uart_xbee_rx, run with a shortened bit period (16 clocks/bit,
// gap timeout of 20 bit times) so the whole sequence stays short.
module tb_uart_xbee_rx;
    localparam int CPB = 16;
    localparam int GAP = 320;

    logic clk_50;
    logic rst_n;
    logic rx;

    uart_xbee_rx_if smp_if ();

    uart_xbee_rx #(.CLKS_PER_BIT(CPB), .GAP_TIMEOUT(GAP)) dut (
        .clk_50 (clk_50),
        .rst_n  (rst_n),
        .rx     (rx),
        .smp    (smp_if.master)
    );

    initial clk_50 = 1'b0;
    always #10 clk_50 = ~clk_50;

    int n_chk  = 0;
    int n_pass = 0;
    int n_samp = 0;
    int n_err  = 0;
    logic [2:0]  last_ch   = '0;
    logic [11:0] last_data = '0;
    logic [14:0] samp_q[$];

    always @(negedge clk_50) begin
        if (smp_if.sample_valid === 1'b1) begin
            n_samp    = n_samp + 1;
            last_ch   = smp_if.sample_ch;
            last_data = smp_if.sample_data;
            samp_q.push_back({smp_if.sample_ch, smp_if.sample_data});
        end
        if (smp_if.frame_err === 1'b1)
            n_err = n_err + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk = n_chk + 1;
        assert (obs === exp) n_pass = n_pass + 1;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk_50);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        rx = 1'b0;
        wait_clks(CPB);
        for (int i = 7; i >= 0; i--) begin
            rx = b[i];
            wait_clks(CPB);
        end
        rx = stop_bit;
        wait_clks(CPB);
        rx = 1'b1;
    endtask

    initial begin
        int          base_samp;
        int          base_err;
        logic [2:0]  ch;
        logic [11:0] dat;
        logic [14:0] got;

        rst_n = 1'b0;
        rx    = 1'b1;
        wait_clks(5);
        chk("rst_valid", 32'(smp_if.sample_valid), 0);
        chk("rst_ferr", 32'(smp_if.frame_err), 0);
        chk("rst_ch", 32'(smp_if.sample_ch), 0);
        chk("rst_data", 32'(smp_if.sample_data), 0);
        chk("rst_errcnt", 32'(smp_if.err_count), 0);
        rst_n = 1'b1;
        wait_clks(10);

        // Basic frame: channel 5, code 0x5A3
        send_byte(8'hD5, 1'b1);
        send_byte(8'hA3, 1'b1);
        wait_clks(10);
        chk("basic_nsamp", 32'(n_samp), 1);
        chk("basic_ch", 32'(last_ch), 5);
        chk("basic_data", 32'(last_data), 32'h5A3);
        chk("basic_errcnt", 32'(smp_if.err_count), 0);
        chk("basic_nerr", 32'(n_err), 0);

        // Low-format byte where a high byte is expected
        send_byte(8'h2A, 1'b1);
        wait_clks(10);
        chk("orphan_nerr", 32'(n_err), 1);
        chk("orphan_errcnt", 32'(smp_if.err_count), 1);
        chk("orphan_nsamp", 32'(n_samp), 1);

        // Gap timeout, then a clean frame
        send_byte(8'h9F, 1'b1);
        wait_clks(GAP + 20);
        chk("gap_nerr", 32'(n_err), 2);
        chk("gap_errcnt", 32'(smp_if.err_count), 2);
        chk("gap_nsamp", 32'(n_samp), 1);
        send_byte(8'hC1, 1'b1);
        send_byte(8'h00, 1'b1);
        wait_clks(10);
        chk("gap_next_nsamp", 32'(n_samp), 2);
        chk("gap_next_ch", 32'(last_ch), 4);
        chk("gap_next_data", 32'(last_data), 32'h100);
        chk("gap_next_nerr", 32'(n_err), 2);

        // Stop bit low in the low byte abandons the frame
        send_byte(8'h85, 1'b1);
        send_byte(8'h3C, 1'b0);
        wait_clks(10);
        chk("stop0_nerr", 32'(n_err), 3);
        chk("stop0_errcnt", 32'(smp_if.err_count), 3);
        chk("stop0_nsamp", 32'(n_samp), 2);
        send_byte(8'hB7, 1'b1);
        send_byte(8'h42, 1'b1);
        wait_clks(10);
        chk("stop0_next_nsamp", 32'(n_samp), 3);
        chk("stop0_next_ch", 32'(last_ch), 3);
        chk("stop0_next_data", 32'(last_data), 32'h742);

        // Short low glitch: false start, no byte, no error; outputs hold
        rx = 1'b0;
        wait_clks(CPB / 4);
        rx = 1'b1;
        wait_clks(CPB * 12);
        chk("glitch_nsamp", 32'(n_samp), 3);
        chk("glitch_nerr", 32'(n_err), 3);
        chk("hold_ch", 32'(smp_if.sample_ch), 3);
        chk("hold_data", 32'(smp_if.sample_data), 32'h742);

        // Sixteen back-to-back frames
        base_samp = samp_q.size();
        for (int i = 0; i < 16; i++) begin
            ch  = 3'(i);
            dat = 12'(i * 273) ^ 12'h5A5;
            send_byte({1'b1, ch, dat[11:8]}, 1'b1);
            send_byte(dat[7:0], 1'b1);
        end
        wait_clks(10);
        chk("b2b_count", 32'(samp_q.size() - base_samp), 16);
        chk("b2b_nerr", 32'(n_err), 3);
        for (int i = 0; i < 16; i++) begin
            ch  = 3'(i);
            dat = 12'(i * 273) ^ 12'h5A5;
            got = (base_samp + i < samp_q.size()) ? samp_q[base_samp + i] : 15'h7FFF;
            chk($sformatf("b2b_sample%0d", i), 32'(got), 32'({ch, dat}));
        end

        // Reset in the middle of the low byte
        send_byte(8'hE7, 1'b1);
        rx = 1'b0;
        wait_clks(CPB);
        rx = 1'b1; wait_clks(CPB);
        rx = 1'b0; wait_clks(CPB);
        rx = 1'b1; wait_clks(CPB / 2);
        base_err  = n_err;
        base_samp = n_samp;
        rst_n = 1'b0;
        wait_clks(3);
        chk("midrst_valid", 32'(smp_if.sample_valid), 0);
        chk("midrst_ferr", 32'(smp_if.frame_err), 0);
        chk("midrst_ch", 32'(smp_if.sample_ch), 0);
        chk("midrst_data", 32'(smp_if.sample_data), 0);
        chk("midrst_errcnt", 32'(smp_if.err_count), 0);
        rx = 1'b1;
        wait_clks(3);
        rst_n = 1'b1;
        wait_clks(CPB * 12);
        chk("midrst_nerr", 32'(n_err - base_err), 0);
        chk("midrst_nsamp", 32'(n_samp - base_samp), 0);
        send_byte(8'h9A, 1'b1);
        send_byte(8'hBC, 1'b1);
        wait_clks(10);
        chk("postrst_nsamp", 32'(n_samp - base_samp), 1);
        chk("postrst_ch", 32'(last_ch), 1);
        chk("postrst_data", 32'(last_data), 32'hABC);
        chk("postrst_errcnt", 32'(smp_if.err_count), 0);

        // Line held low through reset release must not start a byte
        base_err  = n_err;
        base_samp = n_samp;
        rst_n = 1'b0;
        rx    = 1'b0;
        wait_clks(4);
        rst_n = 1'b1;
        wait_clks(CPB * 14);
        rx = 1'b1;
        wait_clks(CPB * 4);
        chk("lowrel_nerr", 32'(n_err - base_err), 0);
        chk("lowrel_errcnt", 32'(smp_if.err_count), 0);
        chk("lowrel_nsamp", 32'(n_samp - base_samp), 0);
        send_byte(8'hF0, 1'b1);
        send_byte(8'h0F, 1'b1);
        wait_clks(10);
        chk("lowrel_next_ch", 32'(last_ch), 7);
        chk("lowrel_next_data", 32'(last_data), 32'h00F);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
